// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: download, CPU and SDRAM command signals around the port arbiter
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 25
);
    logic              dn_go;
    logic              dn_wr;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic              dn_overflow;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_ack;
    logic              mem_req;
    logic              mem_ref;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_ack;
    logic [7:0]        mem_dout;
    logic              busy;

    modport slave (
        input  dn_go, dn_wr, dn_addr, dn_data,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  mem_ack, mem_dout,
        output dn_overflow, cpu_dout, cpu_ack,
        output mem_req, mem_ref, mem_we, mem_addr, mem_din, busy
    );

    modport master (
        output dn_go, dn_wr, dn_addr, dn_data,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output mem_ack, mem_dout,
        input  dn_overflow, cpu_dout, cpu_ack,
        input  mem_req, mem_ref, mem_we, mem_addr, mem_din, busy
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM sequencer port between download FIFO, CPU and refresh
module sdram_port_arbiter #(
    parameter int REFRESH_CYCLES = 328,
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_W         = 25
) (
    input logic                 clk42,
    input logic                 reset_n,
    sdram_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(REFRESH_CYCLES + 1);
    localparam int EW = ADDR_W + 8;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [EW-1:0]     head;
    logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [1:0]        debt_q, debt_d;
    logic [1:0]        state_q, state_d;
    logic              dn_go_q, ovf_q, ovf_d;
    logic              req_q, req_d, ref_q, ref_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d, dout_q, dout_d;
    logic              gcpu_q, gcpu_d, ack_q, ack_d;
    logic              fifo_empty, fifo_full, idle, wrap, done_cmd;
    logic              grant, grant_ref, grant_fifo, grant_cpu, push;

    assign head = fifo_mem[rd_ptr_q[PW-1:0]];

    always_comb begin
        fifo_empty = wr_ptr_q == rd_ptr_q;
        fifo_full  = wr_ptr_q == {~rd_ptr_q[PW], rd_ptr_q[PW-1:0]};
        idle       = state_q == IDLE;
        grant_fifo = idle && !debt_q[1] && !fifo_empty;
        grant_cpu  = idle && !debt_q[1] && fifo_empty && bus.cpu_req;
        grant_ref  = idle && (debt_q[1] || (debt_q == 2'd1 && fifo_empty && !bus.cpu_req));
        grant      = grant_ref || grant_fifo || grant_cpu;
        // a full FIFO still accepts a byte when the head leaves in the same cycle
        push       = bus.dn_wr && (!fifo_full || grant_fifo);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = grant_fifo ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovf_d      = (bus.dn_wr && !push) ? 1'b1 : (bus.dn_go && !dn_go_q) ? 1'b0 : ovf_q;
        wrap       = timer_q == TW'(REFRESH_CYCLES - 1);
        timer_d    = wrap ? '0 : timer_q + 1'b1;
        // wrap and grant together cancel; the wrap alone saturates at 3
        debt_d     = (wrap && !grant_ref && debt_q != 2'd3) ? debt_q + 2'd1 :
                     (!wrap && grant_ref) ? debt_q - 2'd1 : debt_q;
        done_cmd   = state_q == CMD && bus.mem_ack;
        state_d    = grant ? CMD : done_cmd ? DONE : (state_q == DONE) ? IDLE : state_q;
        req_d      = state_d == CMD;
        ref_d      = grant ? grant_ref : ref_q;
        we_d       = grant ? (grant_fifo || (grant_cpu && bus.cpu_we)) : we_q;
        addr_d     = grant_fifo ? head[EW-1:8] : grant_cpu ? bus.cpu_addr : addr_q;
        din_d      = grant_fifo ? head[7:0] : grant_cpu ? bus.cpu_din : din_q;
        gcpu_d     = grant ? grant_cpu : gcpu_q;
        ack_d      = done_cmd && gcpu_q;
        dout_d     = (done_cmd && gcpu_q && !we_q) ? bus.mem_dout : dout_q;
    end

    always_ff @(posedge clk42)
        if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= {bus.dn_addr, bus.dn_data};

    always_ff @(posedge clk42 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            timer_q  <= '0;
            debt_q   <= '0;
            state_q  <= IDLE;
            dn_go_q  <= 1'b0;
            ovf_q    <= 1'b0;
            req_q    <= 1'b0;
            ref_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            gcpu_q   <= 1'b0;
            ack_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            timer_q  <= timer_d;
            debt_q   <= debt_d;
            state_q  <= state_d;
            dn_go_q  <= bus.dn_go;
            ovf_q    <= ovf_d;
            req_q    <= req_d;
            ref_q    <= ref_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            gcpu_q   <= gcpu_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
        end
    end

    assign bus.dn_overflow = ovf_q;
    assign bus.cpu_dout    = dout_q;
    assign bus.cpu_ack     = ack_q;
    assign bus.mem_req     = req_q;
    assign bus.mem_ref     = ref_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_din     = din_q;
    assign bus.busy        = !fifo_empty || state_q != IDLE;
endmodule
